// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one RAM bus between the instruction-fetch read port
// and the load/store port. A MEM-biased arbiter with a bounded MEM streak picks
// the owner, then a small FSM walks the RAM read or write/response handshake,
// with a per-state watchdog that aborts a stalled handshake.
module mem_port_arbiter #(
    parameter int unsigned RAM_AW     = 32,
    parameter int unsigned MEM_STREAK = 4,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_i,
    input  logic [63:0]       if_addr_i,
    output logic [63:0]       if_rdata_o,
    output logic              if_done_o,
    input  logic              mem_req_i,
    input  logic              mem_we_i,
    input  logic [63:0]       mem_addr_i,
    input  logic [63:0]       mem_wdata_i,
    input  logic [63:0]       mem_wmask_i,
    output logic [63:0]       mem_rdata_o,
    output logic              mem_done_o,
    output logic              ram_ren_o,
    output logic [RAM_AW-1:0] ram_raddr_o,
    input  logic              ram_rready_i,
    input  logic [63:0]       ram_rdata_i,
    output logic              ram_wen_o,
    output logic [RAM_AW-1:0] ram_waddr_o,
    output logic [63:0]       ram_wdata_o,
    output logic [63:0]       ram_wmask_o,
    input  logic              ram_wready_i,
    input  logic              ram_bvalid_i,
    output logic              timeout_err_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_IF_RD,
        S_MEM_RD,
        S_MEM_WR,
        S_MEM_WB
    } state_t;

    localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT - 1);
    localparam logic [3:0] STREAK_MAX = 4'(MEM_STREAK);

    state_t     state;
    state_t     state_next;
    logic [7:0] tcnt;
    logic [3:0] streak;
    logic       done_any;
    logic       grant_mem;
    logic       grant_if;
    logic       progress;
    logic       abort;
    logic       if_finish;
    logic       mem_finish;
    logic       unused_addr_hi;

    // Upper address bits beyond the RAM address width are deliberately dropped.
    assign unused_addr_hi = ^{if_addr_i, mem_addr_i};

    // No grant in a done cycle, so a finishing requester can drop its request.
    assign done_any  = if_done_o | mem_done_o;
    assign grant_mem = (state == S_IDLE) && !done_any && mem_req_i &&
                       !(if_req_i && (streak == STREAK_MAX));
    assign grant_if  = (state == S_IDLE) && !done_any && if_req_i && !grant_mem;

    // A handshake step that moves the FSM forward this cycle.
    assign progress = ((state == S_IF_RD || state == S_MEM_RD) && ram_rready_i) ||
                      ((state == S_MEM_WR) && ram_wready_i) ||
                      ((state == S_MEM_WB) && ram_bvalid_i);
    assign abort    = (state != S_IDLE) && !progress && (tcnt == TMO_LAST);

    assign if_finish  = (state == S_IF_RD) && (ram_rready_i || abort);
    assign mem_finish = ((state == S_MEM_RD) && (ram_rready_i || abort)) ||
                        ((state == S_MEM_WR) && ((ram_wready_i && ram_bvalid_i) || abort)) ||
                        ((state == S_MEM_WB) && (ram_bvalid_i || abort));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    // Next-state logic: arbitration in IDLE, handshake sequencing elsewhere.
    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE: begin
                if (grant_mem)     state_next = mem_we_i ? S_MEM_WR : S_MEM_RD;
                else if (grant_if) state_next = S_IF_RD;
            end
            S_IF_RD, S_MEM_RD: begin
                if (ram_rready_i || abort) state_next = S_IDLE;
            end
            S_MEM_WR: begin
                if (ram_wready_i)  state_next = ram_bvalid_i ? S_IDLE : S_MEM_WB;
                else if (abort)    state_next = S_IDLE;
            end
            S_MEM_WB: begin
                if (ram_bvalid_i || abort) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // RAM request lines follow the state directly; only one can be high.
    always_comb begin
        ram_ren_o = 1'b0;
        ram_wen_o = 1'b0;
        unique case (state)
            S_IF_RD, S_MEM_RD: ram_ren_o = 1'b1;
            S_MEM_WR:          ram_wen_o = 1'b1;
            default: ;
        endcase
    end

    // Watchdog: restarts on every state entry, counts cycles spent waiting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                          tcnt <= '0;
        else if (state == S_IDLE || state_next != state)  tcnt <= '0;
        else                                              tcnt <= tcnt + 8'd1;
    end

    // MEM streak: bounds how long IF can be starved by back-to-back MEM grants.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                       streak <= '0;
        else if (!if_req_i || grant_if)                streak <= '0;
        else if (grant_mem && streak != STREAK_MAX)    streak <= streak + 4'd1;
    end

    // Payload capture at grant; RAM-side address/data hold while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_raddr_o <= '0;
            ram_waddr_o <= '0;
            ram_wdata_o <= '0;
            ram_wmask_o <= '0;
        end else if (grant_mem) begin
            if (mem_we_i) begin
                ram_waddr_o <= mem_addr_i[RAM_AW-1:0];
                ram_wdata_o <= mem_wdata_i;
                ram_wmask_o <= mem_wmask_i;
            end else begin
                ram_raddr_o <= mem_addr_i[RAM_AW-1:0];
            end
        end else if (grant_if) begin
            ram_raddr_o <= if_addr_i[RAM_AW-1:0];
        end
    end

    // Completion: read data capture (zero on abort), done pulses, sticky error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_rdata_o    <= '0;
            mem_rdata_o   <= '0;
            if_done_o     <= 1'b0;
            mem_done_o    <= 1'b0;
            timeout_err_o <= 1'b0;
        end else begin
            if_done_o  <= if_finish;
            mem_done_o <= mem_finish;
            if (if_finish)
                if_rdata_o <= ram_rready_i ? ram_rdata_i : '0;
            if ((state == S_MEM_RD) && (ram_rready_i || abort))
                mem_rdata_o <= ram_rready_i ? ram_rdata_i : '0;
            if (abort)
                timeout_err_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed transactions against a small RAM
// responder with programmable handshake delays; expected completions are
// queued per requester and checked by a monitor when the done pulses appear.
module tb_mem_port_arbiter;

    typedef struct {
        logic [63:0] rdata;
        bit          chk_data;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req_i;
    logic [63:0] if_addr_i;
    logic [63:0] if_rdata_o;
    logic        if_done_o;
    logic        mem_req_i;
    logic        mem_we_i;
    logic [63:0] mem_addr_i;
    logic [63:0] mem_wdata_i;
    logic [63:0] mem_wmask_i;
    logic [63:0] mem_rdata_o;
    logic        mem_done_o;
    logic        ram_ren_o;
    logic [31:0] ram_raddr_o;
    logic        ram_rready_i;
    logic [63:0] ram_rdata_i;
    logic        ram_wen_o;
    logic [31:0] ram_waddr_o;
    logic [63:0] ram_wdata_o;
    logic [63:0] ram_wmask_o;
    logic        ram_wready_i;
    logic        ram_bvalid_i;
    logic        timeout_err_o;

    mem_port_arbiter #(
        .RAM_AW(32),
        .MEM_STREAK(4),
        .TIMEOUT(10)
    ) dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i),
        .if_rdata_o(if_rdata_o), .if_done_o(if_done_o),
        .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i),
        .mem_wdata_i(mem_wdata_i), .mem_wmask_i(mem_wmask_i),
        .mem_rdata_o(mem_rdata_o), .mem_done_o(mem_done_o),
        .ram_ren_o(ram_ren_o), .ram_raddr_o(ram_raddr_o),
        .ram_rready_i(ram_rready_i), .ram_rdata_i(ram_rdata_i),
        .ram_wen_o(ram_wen_o), .ram_waddr_o(ram_waddr_o),
        .ram_wdata_o(ram_wdata_o), .ram_wmask_o(ram_wmask_o),
        .ram_wready_i(ram_wready_i), .ram_bvalid_i(ram_bvalid_i),
        .timeout_err_o(timeout_err_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    exp_t if_q[$];
    exp_t mem_q[$];

    // RAM responder configuration and observations
    int          rd_delay = 1;
    int          wr_delay = 0;
    int          b_delay  = 0;
    int          rcnt = 0, wcnt = 0, bpend = 0;
    int          rlen = 0, wlen = 0;
    logic [31:0] last_raddr = '0;
    logic [31:0] last_waddr = '0;
    logic [63:0] last_wdata = '0;
    logic [63:0] last_wmask = '0;
    bit          both_seen = 1'b0;

    task automatic check64(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // RAM responder: updates its handshake outputs just after each rising edge.
    initial begin
        ram_rready_i = 1'b0;
        ram_rdata_i  = '0;
        ram_wready_i = 1'b0;
        ram_bvalid_i = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                rcnt = 0; wcnt = 0; bpend = 0;
                ram_rready_i = 1'b0; ram_wready_i = 1'b0; ram_bvalid_i = 1'b0;
            end else begin
                if (ram_ren_o) begin
                    rcnt++;
                    if (rcnt == rd_delay + 1) begin
                        ram_rready_i = 1'b1;
                        ram_rdata_i  = {ram_raddr_o ^ 32'hA5A5_5A5A, ram_raddr_o};
                        last_raddr   = ram_raddr_o;
                    end else begin
                        ram_rready_i = 1'b0;
                        ram_rdata_i  = 64'hDEAD_BEEF_DEAD_BEEF;
                    end
                end else begin
                    if (rcnt > 0) rlen = rcnt;
                    rcnt = 0;
                    ram_rready_i = 1'b0;
                    ram_rdata_i  = 64'hDEAD_BEEF_DEAD_BEEF;
                end
                if (ram_wen_o) begin
                    wcnt++;
                    ram_wready_i = (wcnt == wr_delay + 1);
                    ram_bvalid_i = ram_wready_i && (b_delay == 0);
                    if (ram_wready_i) begin
                        last_waddr = ram_waddr_o;
                        last_wdata = ram_wdata_o;
                        last_wmask = ram_wmask_o;
                        if (b_delay != 0) bpend = b_delay;
                    end
                end else begin
                    if (wcnt > 0) wlen = wcnt;
                    wcnt = 0;
                    ram_wready_i = 1'b0;
                    if (bpend > 0) begin
                        bpend--;
                        ram_bvalid_i = (bpend == 0);
                    end else begin
                        ram_bvalid_i = 1'b0;
                    end
                end
            end
        end
    end

    // Monitor: pops the expected completion whenever a done pulse is seen.
    always @(negedge clk) begin
        exp_t e;
        if (ram_ren_o && ram_wen_o) both_seen = 1'b1;
        if (if_done_o) begin
            if (if_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL if_done_unexpected: got pulse expected none (cycle %0d)", cyc);
            end else begin
                e = if_q.pop_front();
                check64("if_done_cycle", 64'(cyc), 64'(e.cyc));
                if (e.chk_data) check64("if_rdata", if_rdata_o, e.rdata);
            end
        end
        if (mem_done_o) begin
            if (mem_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL mem_done_unexpected: got pulse expected none (cycle %0d)", cyc);
            end else begin
                e = mem_q.pop_front();
                check64("mem_done_cycle", 64'(cyc), 64'(e.cyc));
                if (e.chk_data) check64("mem_rdata", mem_rdata_o, e.rdata);
            end
        end
    end

    task automatic push_if(input logic [63:0] d, input bit c, input int at);
        exp_t e;
        e.rdata = d; e.chk_data = c; e.cyc = at;
        if_q.push_back(e);
    endtask

    task automatic push_mem(input logic [63:0] d, input bit c, input int at);
        exp_t e;
        e.rdata = d; e.chk_data = c; e.cyc = at;
        mem_q.push_back(e);
    endtask

    // Waits (bounded) for a done pulse, then drops that requester's req in the done cycle.
    task automatic wait_done(input bit is_if, input int limit, input string nm);
        int n = 0;
        bit got = 1'b0;
        while (!got && n < limit) begin
            @(negedge clk);
            n++;
            if (is_if ? if_done_o : mem_done_o) got = 1'b1;
        end
        if (is_if) if_req_i = 1'b0;
        else       mem_req_i = 1'b0;
        check64(nm, 64'(got), 64'd1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        int n_if;
        int n;
        rst = 1'b1;
        if_req_i = 1'b0; if_addr_i = '0;
        mem_req_i = 1'b0; mem_we_i = 1'b0; mem_addr_i = '0;
        mem_wdata_i = '0; mem_wmask_i = '0;
        repeat (3) @(posedge clk);
        #1;
        check64("rst_ren_wen", {62'd0, ram_ren_o, ram_wen_o}, 64'd0);
        check64("rst_done", {62'd0, if_done_o, mem_done_o}, 64'd0);
        check64("rst_rdata", if_rdata_o | mem_rdata_o, 64'd0);
        check64("rst_addr", {ram_raddr_o, ram_waddr_o}, 64'd0);
        check64("rst_wdata_mask", ram_wdata_o | ram_wmask_o, 64'd0);
        check64("rst_err", 64'(timeout_err_o), 64'd0);
        rst = 1'b0;
        idle(2);

        // IF-only read, rready one cycle after ren
        rd_delay = 1;
        k = cyc;
        push_if(64'h25A5_5A5A_8000_0000, 1'b1, k + 3);
        if_addr_i = 64'h0000_0000_8000_0000; if_req_i = 1'b1;
        wait_done(1'b1, 20, "t1_if_done_seen");
        check64("t1_raddr", 64'(last_raddr), 64'h8000_0000);
        check64("t1_ren_len", 64'(rlen), 64'd2);
        idle(3);

        // simultaneous IF and MEM read: MEM first, IF the cycle after mem_done
        k = cyc;
        push_mem(64'hA5A5_4A5A_0000_1000, 1'b1, k + 3);
        push_if(64'h25A5_5A1A_8000_0040, 1'b1, k + 7);
        mem_addr_i = 64'h1000; mem_we_i = 1'b0; mem_req_i = 1'b1;
        if_addr_i = 64'h8000_0040; if_req_i = 1'b1;
        wait_done(1'b0, 20, "t2_mem_done_seen");
        wait_done(1'b1, 20, "t2_if_done_seen");
        idle(3);

        // streak: both held; MEM x4, IF x1, repeating
        k = cyc;
        for (int i = 0; i < 10; i++) begin
            if (i == 4 || i == 9) push_if(64'h25A5_5B5A_8000_0100, 1'b1, k + 3 + 4 * i);
            else                  push_mem(64'hA5A5_7A5A_0000_2000, 1'b1, k + 3 + 4 * i);
        end
        mem_addr_i = 64'h2000; mem_req_i = 1'b1;
        if_addr_i = 64'h8000_0100; if_req_i = 1'b1;
        n_if = 0; n = 0;
        while (n_if < 2 && n < 200) begin
            @(negedge clk);
            n++;
            if (if_done_o) n_if++;
        end
        if_req_i = 1'b0; mem_req_i = 1'b0;
        check64("t3_if_grants", 64'(n_if), 64'd2);
        idle(3);

        // write: wready after 3 extra cycles, bvalid 2 after wready
        wr_delay = 3; b_delay = 2;
        k = cyc;
        push_mem('0, 1'b0, k + 7);
        mem_we_i = 1'b1; mem_addr_i = 64'h3000;
        mem_wdata_i = 64'h1122_3344_5566_7788; mem_wmask_i = 64'hFFFF_0000_FFFF_0000;
        mem_req_i = 1'b1;
        wait_done(1'b0, 30, "t4_done_seen");
        check64("t4_wen_len", 64'(wlen), 64'd4);
        check64("t4_waddr", 64'(last_waddr), 64'h3000);
        check64("t4_wdata", last_wdata, 64'h1122_3344_5566_7788);
        check64("t4_wmask", last_wmask, 64'hFFFF_0000_FFFF_0000);
        idle(3);

        // write with wready and bvalid together
        wr_delay = 0; b_delay = 0;
        k = cyc;
        push_mem('0, 1'b0, k + 2);
        mem_addr_i = 64'h3008; mem_wdata_i = 64'hCAFE_F00D_0123_4567; mem_wmask_i = '1;
        mem_req_i = 1'b1;
        wait_done(1'b0, 20, "t5_done_seen");
        check64("t5_wen_len", 64'(wlen), 64'd1);
        check64("t5_wdata", last_wdata, 64'hCAFE_F00D_0123_4567);
        mem_we_i = 1'b0;
        idle(3);

        // read timeout: RAM never answers
        check64("t6_err_before", 64'(timeout_err_o), 64'd0);
        rd_delay = 1000;
        k = cyc;
        push_if(64'h0, 1'b1, k + 11);
        if_addr_i = 64'h8000_0200; if_req_i = 1'b1;
        wait_done(1'b1, 40, "t6_done_seen");
        check64("t6_ren_len", 64'(rlen), 64'd10);
        check64("t6_err", 64'(timeout_err_o), 64'd1);
        idle(2);
        rd_delay = 1;
        k = cyc;
        push_if(64'h25A5_595A_8000_0300, 1'b1, k + 3);
        if_addr_i = 64'h8000_0300; if_req_i = 1'b1;
        wait_done(1'b1, 20, "t7_done_seen");
        check64("t7_err_sticky", 64'(timeout_err_o), 64'd1);
        idle(3);

        // async reset while waiting for bvalid
        wr_delay = 0; b_delay = 20;
        mem_we_i = 1'b1; mem_addr_i = 64'h4000; mem_wdata_i = 64'h55; mem_wmask_i = '1;
        mem_req_i = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1; mem_req_i = 1'b0; mem_we_i = 1'b0;
        #1;
        check64("t8_rst_addr", {ram_raddr_o, ram_waddr_o}, 64'd0);
        check64("t8_rst_data", if_rdata_o | mem_rdata_o | ram_wdata_o, 64'd0);
        check64("t8_rst_flags", {60'd0, ram_ren_o, ram_wen_o, mem_done_o, timeout_err_o}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        b_delay = 0;
        idle(30);
        k = cyc;
        push_if(64'h25A5_5E5A_8000_0400, 1'b1, k + 3);
        if_addr_i = 64'h8000_0400; if_req_i = 1'b1;
        wait_done(1'b1, 20, "t9_done_seen");
        idle(3);

        check64("single_req_line", 64'(both_seen), 64'd0);
        check64("queues_drained", 64'(if_q.size() + mem_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
